mem_responder: RTL and testbench

- Memory-side responder for the cache line-fill / write-back protocol (mem_read, mem_write, mem_addr, mem_wdata, mem_rdata, mem_ready).
- Serves 128-bit line reads and writes from internal storage after a fixed, programmable latency, signalling completion with a single-cycle mem_ready pulse.
- Sits on the memory side of the I/D caches in simulation and FPGA builds; it replaces the external slow-memory model.

---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 111 +++++++++++
 tb/tb_mem_responder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Line-fill / write-back bus between a cache (master) and the memory responder (slave).
// A request is held by the master until it sees the single-cycle mem_ready pulse.
interface mem_responder_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              err;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, err
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: serves 128-bit line reads/writes from internal storage
// after a fixed LATENCY, completing each transaction with a one-cycle mem_ready.
module mem_responder #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 8
) (
    input  logic                 clk,
    input  logic                 proc_reset,
    mem_responder_if.slave       bus,
    output logic [1:0]           o_dbg_state
);
    // Handshake: a request (mem_read/mem_write) is accepted when seen high in IDLE;
    // addr/wdata/op are latched then, so the master may change them afterwards.
    // The master holds the request until it observes mem_ready, which is high for
    // exactly one cycle (DONE). A request still high in the following IDLE cycle
    // is accepted as a new transaction.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [7:0]              r_cnt;
    logic [7:0]              w_cnt_next;
    logic                    w_accept;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [DATA_W-1:0]       r_wdata;
    logic                    r_is_wr;
    logic [DATA_W-1:0]       r_rdata;
    logic                    r_err;
    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic                    w_req;
    logic                    w_unused_addr;

    assign w_req         = bus.mem_read | bus.mem_write;
    // Upper address bits alias onto the stored lines by design.
    assign w_unused_addr = ^bus.mem_addr[ADDR_W-1:DEPTH_LOG2];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = CNT_INIT;
                    w_state_next = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                w_cnt_next = r_cnt - 8'd1;
                if (r_cnt == 8'd1) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_is_wr <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_idx   <= bus.mem_addr[DEPTH_LOG2-1:0];
                r_wdata <= bus.mem_wdata;
                r_is_wr <= bus.mem_write;
                if (bus.mem_read && bus.mem_write) begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == DONE) begin
                if (r_is_wr) begin
                    r_mem[r_idx] <= r_wdata;
                end else begin
                    r_rdata <= r_mem[r_idx];
                end
            end
        end
    end

    // Read data is presented straight from storage in DONE, then held in r_rdata.
    assign bus.mem_rdata = (r_state == DONE && !r_is_wr) ? r_mem[r_idx] : r_rdata;
    assign bus.mem_ready = (r_state == DONE);
    assign bus.err       = r_err;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a LATENCY=8 and a LATENCY=1 instance
// driven by a transaction task, with an expected-read-data queue as scoreboard.
module tb_mem_responder;
    logic clk;
    logic proc_reset;
    logic [1:0] dbg_state8;
    logic [1:0] dbg_state1;

    mem_responder_if #(.ADDR_W(28), .DATA_W(128)) b8 ();
    mem_responder_if #(.ADDR_W(28), .DATA_W(128)) b1 ();

    mem_responder #(.ADDR_W(28), .DATA_W(128), .DEPTH_LOG2(8), .LATENCY(8)) dut8 (
        .clk(clk), .proc_reset(proc_reset), .bus(b8), .o_dbg_state(dbg_state8)
    );
    mem_responder #(.ADDR_W(28), .DATA_W(128), .DEPTH_LOG2(8), .LATENCY(1)) dut1 (
        .clk(clk), .proc_reset(proc_reset), .bus(b1), .o_dbg_state(dbg_state1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] exp_q[$];
    logic [127:0] model [2][256];
    logic [127:0] last_rd [2];
    logic         exp_err [2];

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) model[s][i] = '0;
            last_rd[s] = '0;
            exp_err[s] = 1'b0;
        end
        exp_q.delete();
    endtask

    // driver tasks
    task automatic drive(input bit sel, input bit rd, input bit wr,
                         input logic [27:0] addr, input logic [127:0] wdata);
        if (sel) begin
            b1.mem_read = rd; b1.mem_write = wr; b1.mem_addr = addr; b1.mem_wdata = wdata;
        end else begin
            b8.mem_read = rd; b8.mem_write = wr; b8.mem_addr = addr; b8.mem_wdata = wdata;
        end
    endtask

    function automatic logic get_ready(input bit sel);
        return sel ? b1.mem_ready : b8.mem_ready;
    endfunction

    function automatic logic [127:0] get_rdata(input bit sel);
        return sel ? b1.mem_rdata : b8.mem_rdata;
    endfunction

    function automatic logic get_err(input bit sel);
        return sel ? b1.err : b8.err;
    endfunction

    // Called at a negedge; raises the request, waits for ready, checks latency,
    // read data and err, then checks ready drops. With chain=1 the request is
    // left high so the caller can issue the next transaction in the IDLE cycle.
    task automatic run_txn(input bit sel, input bit rd, input bit wr,
                           input logic [27:0] addr, input logic [127:0] wdata,
                           input bit chain, input int lat);
        int n;
        logic rdy;
        logic [7:0] idx;
        logic [127:0] exp;
        idx = addr[7:0];
        drive(sel, rd, wr, addr, wdata);
        if (wr) begin
            exp = last_rd[sel];
            model[sel][idx] = wdata;
        end else begin
            exp = model[sel][idx];
            last_rd[sel] = exp;
        end
        if (rd && wr) exp_err[sel] = 1'b1;
        exp_q.push_back(exp);
        n = 0;
        rdy = 1'b0;
        while (!rdy && n <= lat + 4) begin
            @(negedge clk);
            n++;
            rdy = get_ready(sel);
            if (n == 1 && lat > 1 && !rdy)
                drive(sel, rd, wr, 28'($urandom), {$urandom, $urandom, $urandom, $urandom});
        end
        if (!rdy) begin
            check("ready_timeout", 1'b0, 1'b1);
            exp_q.delete();
        end else begin
            check("latency", 128'(n), 128'(lat));
            check("rdata", get_rdata(sel), exp_q.pop_front());
            check("err", 128'(get_err(sel)), 128'(exp_err[sel]));
        end
        @(negedge clk);
        check("ready_low", 128'(get_ready(sel)), 128'd0);
        if (!chain) drive(sel, 1'b0, 1'b0, addr, wdata);
    endtask

    logic [127:0] data_a;
    logic [127:0] data_b;
    logic [127:0] data_c;
    logic [127:0] data_d;

    initial begin
        data_a = 128'hA5A5_0001_0002_0003_0004_0005_0006_A5A5;
        data_b = 128'hBBBB_1111_2222_3333_4444_5555_6666_BBBB;
        data_c = 128'hCCCC_9999_8888_7777_6666_5555_4444_CCCC;
        data_d = 128'hDDDD_0F0F_F0F0_1234_5678_9ABC_DEF0_DDDD;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        model_reset();
        proc_reset = 1'b1;
        repeat (3) @(negedge clk);
        proc_reset = 1'b0;
        @(negedge clk);
        check("rst_state", 128'(dbg_state8), 128'd0);
        check("rst_ready", 128'(b8.mem_ready), 128'd0);
        check("rst_rdata", b8.mem_rdata, 128'd0);
        check("rst_err", 128'(b8.err), 128'd0);
        repeat (5) @(negedge clk);

        // read of a cleared line
        run_txn(1'b0, 1'b1, 1'b0, 28'h0000005, '0, 1'b0, 8);
        @(negedge clk);
        // write then read back
        run_txn(1'b0, 1'b0, 1'b1, 28'h12, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, 8);
        run_txn(1'b0, 1'b1, 1'b0, 28'h12, '0, 1'b0, 8);
        // alias: 0x103 and 0x003 share line 3
        run_txn(1'b0, 1'b0, 1'b1, 28'h0000103, data_a, 1'b0, 8);
        run_txn(1'b0, 1'b1, 1'b0, 28'h0000003, '0, 1'b0, 8);
        // write-back then fill with the request switched in the gap cycle
        run_txn(1'b0, 1'b0, 1'b1, 28'h40, data_c, 1'b0, 8);
        run_txn(1'b0, 1'b0, 1'b1, 28'h20, data_b, 1'b1, 8);
        run_txn(1'b0, 1'b1, 1'b0, 28'h40, '0, 1'b0, 8);
        run_txn(1'b0, 1'b1, 1'b0, 28'h20, '0, 1'b0, 8);
        // simultaneous read+write: write wins, err becomes sticky
        run_txn(1'b0, 1'b1, 1'b1, 28'h9, data_d, 1'b0, 8);
        run_txn(1'b0, 1'b1, 1'b0, 28'h9, '0, 1'b0, 8);
        // random traffic over a small set of lines
        for (int k = 0; k < 8; k++) begin
            bit w;
            w = 1'($urandom_range(0, 1));
            run_txn(1'b0, !w, w, 28'($urandom_range(0, 3)) | 28'($urandom_range(0, 15) << 8),
                    {$urandom, $urandom, $urandom, $urandom}, 1'b0, 8);
        end

        // reset in the middle of a pending write to line 7
        drive(1'b0, 1'b0, 1'b1, 28'h7, data_a);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("pend_ready", 128'(b8.mem_ready), 128'd0);
        end
        proc_reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 28'h7, data_a);
        @(negedge clk);
        check("abort_ready", 128'(b8.mem_ready), 128'd0);
        proc_reset = 1'b0;
        model_reset();
        check("abort_state", 128'(dbg_state8), 128'd0);
        check("abort_err", 128'(b8.err), 128'd0);
        @(negedge clk);
        check("abort_ready2", 128'(b8.mem_ready), 128'd0);
        run_txn(1'b0, 1'b1, 1'b0, 28'h7, '0, 1'b0, 8);

        // LATENCY=1 instance
        run_txn(1'b1, 1'b0, 1'b1, 28'h33, data_b, 1'b0, 1);
        run_txn(1'b1, 1'b1, 1'b0, 28'h33, '0, 1'b1, 1);
        run_txn(1'b1, 1'b1, 1'b1, 28'h34, data_d, 1'b1, 1);
        run_txn(1'b1, 1'b1, 1'b0, 28'h34, '0, 1'b0, 1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
